// File: rtl/max_reduce_ctrl.sv
// max_reduce_ctrl: streams beats into an external max tree and folds its
// outputs into one queued result per vector, credit-guarded against overflow.
module max_reduce_ctrl #(
  parameter int NUM       = 4,
  parameter int SIZE      = 8,
  parameter int TREE_LAT  = 2,
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM*SIZE-1:0] in_data,
  input  logic                in_last,
  output logic [NUM*SIZE-1:0] tree_din,
  input  logic [SIZE-1:0]     tree_dout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SIZE-1:0]     out_data,
  output logic [CNT_W-1:0]    out_beats
);

  localparam int CRW = $clog2(OUT_DEPTH + 1);
  localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  logic [CRW-1:0]      credits;
  logic [CRW-1:0]      credits_nx;
  logic                rdy_q;
  logic                in_vec;
  logic                accept;
  logic                dec;
  logic                pop;
  logic                push;

  logic [TREE_LAT-1:0] tag_v;
  logic [TREE_LAT-1:0] tag_f;
  logic [TREE_LAT-1:0] tag_l;
  logic                ev;
  logic                ef;
  logic                el;

  logic [SIZE-1:0]     acc;
  logic [CNT_W-1:0]    cnt;
  logic [SIZE-1:0]     m;
  logic [CNT_W-1:0]    cnt_nx;

  logic [SIZE-1:0]     fd [OUT_DEPTH];
  logic [CNT_W-1:0]    fb [OUT_DEPTH];
  logic [PW-1:0]       rd;
  logic [PW-1:0]       wr;
  logic [PW-1:0]       rd_nx;
  logic [PW-1:0]       wr_nx;
  logic [CRW-1:0]      occ;

  assign tree_din  = in_data;
  assign in_ready  = rdy_q;
  assign accept    = in_valid & rdy_q;
  assign dec       = accept & in_last;
  assign out_valid = (occ != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = fd[rd];
  assign out_beats = fb[rd];

  assign ev = tag_v[TREE_LAT-1];
  assign ef = tag_f[TREE_LAT-1];
  assign el = tag_l[TREE_LAT-1];

  // credit arithmetic: one credit per vector, returned on pop
  always_comb begin
    credits_nx = credits;
    if (dec && !pop) begin
      credits_nx = credits - CRW'(1);
    end else if (pop && !dec) begin
      credits_nx = credits + CRW'(1);
    end
  end

  // credit counter and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= CRW'(OUT_DEPTH);
      rdy_q   <= 1'b0;
    end else begin
      credits <= credits_nx;
      rdy_q   <= (credits_nx != '0);
    end
  end

  // mid-vector flag; the next accepted beat is a first beat when clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vec <= 1'b0;
    end else if (accept) begin
      in_vec <= ~in_last;
    end
  end

  // tag pipe tracking accepted beats alongside the tree latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_f <= '0;
      tag_l <= '0;
    end else begin
      tag_v[0] <= accept;
      tag_f[0] <= ~in_vec;
      tag_l[0] <= in_last;
      for (int i = 1; i < TREE_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_f[i] <= tag_f[i-1];
        tag_l[i] <= tag_l[i-1];
      end
    end
  end

  // fold the emerging tree result into the running maximum and count
  always_comb begin
    m      = tree_dout;
    cnt_nx = CNT_W'(1);
    if (!ef) begin
      m      = (tree_dout > acc) ? tree_dout : acc;
      cnt_nx = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    end
    push = ev & el;
  end

  // accumulator and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (ev) begin
      acc <= m;
      cnt <= cnt_nx;
    end
  end

  // ring pointer wrap
  always_comb begin
    wr_nx = (wr == PW'(OUT_DEPTH - 1)) ? '0 : wr + PW'(1);
    rd_nx = (rd == PW'(OUT_DEPTH - 1)) ? '0 : rd + PW'(1);
  end

  // result fifo
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd  <= '0;
      wr  <= '0;
      occ <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fd[i] <= '0;
        fb[i] <= '0;
      end
    end else begin
      if (push) begin
        fd[wr] <= m;
        fb[wr] <= cnt_nx;
        wr     <= wr_nx;
      end
      if (pop) begin
        rd <= rd_nx;
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + CRW'(1);
        2'b01:   occ <= occ - CRW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_max_reduce_ctrl.sv
// tb_max_reduce_ctrl: scoreboard bench with a pipelined max tree model
// and a whole-vector reference for each expected result.
module tb_max_reduce_ctrl;

  localparam int NUM       = 4;
  localparam int SIZE      = 8;
  localparam int TREE_LAT  = 2;
  localparam int OUT_DEPTH = 2;
  localparam int CNT_W     = 8;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] b;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] tree_din;
  logic [7:0]  tree_dout;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [7:0]  out_beats;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  bit   lat_chk = 0;
  int   rmode = 1;
  bit   rbit = 0;
  exp_t sbq[$];
  int   pop_cyc[$];
  logic [31:0] vb[$];
  logic [7:0]  tp [TREE_LAT];

  max_reduce_ctrl #(
    .NUM(NUM), .SIZE(SIZE), .TREE_LAT(TREE_LAT),
    .OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .tree_din(tree_din), .tree_dout(tree_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_beats(out_beats)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] lmax(input logic [31:0] w);
    logic [7:0] r;
    r = 0;
    for (int k = 0; k < NUM; k++)
      if (w[k*8 +: 8] > r) r = w[k*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] pk(input int a, input int b,
                                     input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // external max tree: fixed latency, never stalls, not reset
  always @(posedge clk) begin
    tp[0] <= lmax(tree_din);
    for (int i = 1; i < TREE_LAT; i++) tp[i] <= tp[i-1];
  end
  assign tree_dout = tp[TREE_LAT-1];

  always @(negedge clk) rbit = ($urandom_range(0, 9) < 7);
  always_comb out_ready = (rmode == 1) || (rmode == 2 && rbit);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic slot();
    @(negedge clk);
    #1;
  endtask

  // drive vb[] as one vector; expected result is queued on last accept
  task automatic send_vec();
    int n;
    int t;
    logic [7:0] mx;
    logic [7:0] cb;
    n  = vb.size();
    mx = 0;
    for (int i = 0; i < n; i++)
      if (lmax(vb[i]) > mx) mx = lmax(vb[i]);
    cb = (n > 255) ? 8'd255 : 8'(n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1;
      in_data  = vb[i];
      in_last  = (i == n - 1);
      t = 0;
      while (!in_ready && t < 500) begin
        slot();
        t++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready=0 expected 1");
        in_valid = 0;
        in_last  = 0;
        return;
      end
      if (i == n - 1) begin
        sbq.push_back(exp_t'{d: mx, b: cb});
        last_acc_cyc = cyc;
        chk("credit_bound", int'(sbq.size() <= OUT_DEPTH), 1);
      end
      slot();
    end
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic one(input logic [31:0] w);
    vb.delete();
    vb.push_back(w);
    send_vec();
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      if (sbq.size() == 0 && !out_valid) break;
      slot();
    end
    chk("drain_empty", sbq.size(), 0);
    chk("drain_valid", out_valid, 0);
  endtask

  // monitor: pop-and-compare, hold stability, first-result latency
  initial begin
    bit held;
    bit prev_v;
    logic [7:0] hd;
    logic [7:0] hb;
    exp_t e;
    held   = 0;
    prev_v = 0;
    hd     = 0;
    hb     = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held   = 0;
        prev_v = 0;
      end else begin
        if (held && out_valid) begin
          chk("hold_data", out_data, hd);
          chk("hold_beats", out_beats, hb);
        end
        if (out_valid && !prev_v && lat_chk) begin
          chk("latency", cyc - last_acc_cyc, TREE_LAT + 1);
          lat_chk = 0;
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: data=%0d beats=%0d none expected",
                     out_data, out_beats);
          end else begin
            e = sbq.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_beats", out_beats, e.b);
          end
          pop_cyc.push_back(cyc);
        end
        held   = out_valid && !out_ready;
        hd     = out_data;
        hb     = out_beats;
        prev_v = out_valid;
      end
    end
  end

  initial begin
    rst_n    = 1;
    in_valid = 0;
    in_last  = 0;
    in_data  = 0;
    #1 rst_n = 0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_beats", out_beats, 0);
    repeat (3) slot();
    chk("rst_hold_ready", in_ready, 0);
    rst_n = 1;
    slot();
    chk("ready_after_release", in_ready, 1);

    // three-beat vector with latency check
    rmode   = 1;
    lat_chk = 1;
    vb.delete();
    vb.push_back(pk(3, 9, 1, 2));
    vb.push_back(pk(7, 0, 5, 4));
    vb.push_back(pk(8, 8, 6, 1));
    send_vec();
    drain();
    chk("latency_seen", lat_chk, 0);

    // single-beat vectors, back to back
    one(pk(0, 255, 17, 1));
    drain();
    one(pk(5, 1, 0, 3));
    one(pk(2, 0, 1, 2));
    drain();
    chk("b2b_gap", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2], 1);

    // backpressure: credits exhaust after two vectors
    rmode = 0;
    one(pk(11, 12, 13, 14));
    one(pk(21, 22, 23, 24));
    chk("bp_ready_drop", in_ready, 0);
    fork
      one(pk(31, 32, 33, 34));
      begin
        repeat (4) slot();
        chk("bp_stall_ready", in_ready, 0);
        chk("bp_full_valid", out_valid, 1);
        chk("bp_queued", sbq.size(), 2);
        rmode = 1;
        slot();
        rmode = 0;
        chk("bp_ready_back", in_ready, 1);
      end
    join
    rmode = 1;
    drain();

    // last-beat accept coincides with pop at credits=1
    rmode = 0;
    one(pk(40, 41, 42, 43));
    repeat (4) slot();
    chk("sim_valid", out_valid, 1);
    chk("sim_ready_pre", in_ready, 1);
    rmode = 1;
    one(pk(50, 51, 52, 53));
    rmode = 0;
    chk("sim_ready_post", in_ready, 1);
    one(pk(60, 61, 62, 63));
    chk("sim_credit_one", in_ready, 0);
    rmode = 1;
    drain();

    // 300-beat vector: count saturates, max in final beat
    vb.delete();
    for (int i = 0; i < 300; i++)
      vb.push_back(pk($urandom_range(0, 199), $urandom_range(0, 199),
                      $urandom_range(0, 199), $urandom_range(0, 199)));
    vb[299][23:16] = 8'd200;
    send_vec();
    drain();

    // reset with beats in flight and a result queued
    rmode = 0;
    one(pk(70, 71, 72, 73));
    repeat (4) slot();
    chk("pre_rst_valid", out_valid, 1);
    in_valid = 1;
    in_last  = 0;
    in_data  = pk(250, 250, 250, 250);
    chk("pre_rst_ready", in_ready, 1);
    slot();
    slot();
    in_valid = 0;
    rst_n    = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    sbq.delete();
    lat_chk = 0;
    #2 rst_n = 1;
    slot();
    chk("post_rst_ready", in_ready, 1);
    one(pk(4, 4, 4, 4));
    one(pk(1, 2, 3, 6));
    chk("post_rst_credits", in_ready, 0);
    rmode = 1;
    drain();

    // randomized vectors under random backpressure
    rmode = 2;
    for (int v = 0; v < 40; v++) begin
      int n;
      n = $urandom_range(1, 6);
      vb.delete();
      for (int i = 0; i < n; i++)
        vb.push_back($urandom());
      send_vec();
      if ($urandom_range(0, 3) == 0) slot();
    end
    rmode = 1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
